// File: rtl/rf_mp_sb_if.sv
// rf_mp_sb_if: decode-side bus of the multi-port register file.
//   master: drives read selects, write/writeback ports and issue requests
//   slave : returns read data, per-port RAW hazard flags, issue stall and busy count
interface rf_mp_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);
    logic [NUM_RD*AW-1:0]     rd_sel_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic [NUM_WR-1:0]        wr_en_i;
    logic [NUM_WR*AW-1:0]     wr_sel_i;
    logic [NUM_WR*DATA_W-1:0] wr_data_i;
    logic                     issue_en_i;
    logic [AW-1:0]            issue_sel_i;
    logic                     issue_stall_o;
    logic [CW-1:0]            busy_cnt_o;
    modport master (
        output rd_sel_i, wr_en_i, wr_sel_i, wr_data_i, issue_en_i, issue_sel_i,
        input  rd_data_o, rd_busy_o, issue_stall_o, busy_cnt_o
    );
    modport slave (
        input  rd_sel_i, wr_en_i, wr_sel_i, wr_data_i, issue_en_i, issue_sel_i,
        output rd_data_o, rd_busy_o, issue_stall_o, busy_cnt_o
    );
endinterface

// File: rtl/rf_mp_sb.sv
// rf_mp_sb: multi-port register file with write-through bypass, optional zero register and busy scoreboard.
//   clk_i   : clock, rising edge
//   rst_n_i : synchronous active-low reset
//   bus     : rf_mp_sb_if slave (read ports, write ports, issue request, hazard/stall/count outputs)
module rf_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input logic         clk_i,
    input logic         rst_n_i,
    rf_mp_sb_if.slave   bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d, ret, iss;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                stall;
    logic [AW-1:0]       rs [NUM_RD];
    logic [DATA_W-1:0]   rv [NUM_RD];

    // A select is live when it names a real register that is not the hardwired zero.
    function automatic logic live(input logic [AW-1:0] s);
        return (32'(s) < NUM_REGS) && !(ZERO_REG && s == '0);
    endfunction

    always_comb begin
        ret = '0;
        regs_d = regs_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (bus.wr_en_i[w] && live(bus.wr_sel_i[w*AW +: AW])) begin
                ret[bus.wr_sel_i[w*AW +: AW]] = 1'b1;
                regs_d[bus.wr_sel_i[w*AW +: AW]] = bus.wr_data_i[w*DATA_W +: DATA_W];
            end
        end
        // A retiring write frees the destination this cycle, so it does not block a new issue.
        stall = bus.issue_en_i && live(bus.issue_sel_i) && busy_q[bus.issue_sel_i] && !ret[bus.issue_sel_i];
        iss = '0;
        if (bus.issue_en_i && live(bus.issue_sel_i) && !stall)
            iss[bus.issue_sel_i] = 1'b1;
        busy_d = iss | (busy_q & ~ret);
        cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++)
            cnt_d = cnt_d + CW'(busy_d[r]);
        bus.rd_data_o = '0;
        bus.rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rs[k] = bus.rd_sel_i[k*AW +: AW];
            rv[k] = regs_q[rs[k]];
            for (int w = 0; w < NUM_WR; w++)
                if (bus.wr_en_i[w] && bus.wr_sel_i[w*AW +: AW] == rs[k])
                    rv[k] = bus.wr_data_i[w*DATA_W +: DATA_W];
            bus.rd_data_o[k*DATA_W +: DATA_W] = live(rs[k]) ? rv[k] : '0;
            bus.rd_busy_o[k] = live(rs[k]) && busy_q[rs[k]] && !ret[rs[k]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.issue_stall_o = stall;
    assign bus.busy_cnt_o    = cnt_q;
endmodule

// File: tb/tb_rf_mp_sb.sv
// tb_rf_mp_sb: scoreboard-driven bench for rf_mp_sb (reset, bypass, zero reg, scoreboard, reset mid-op, random).
module tb_rf_mp_sb;
    localparam int DW = 32, NR = 32, NRD = 2, NWR = 2, AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] exp_q [$];
    logic [31:0] e;
    int n_cmp = 0, n_bad = 0;

    rf_mp_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();
    rf_mp_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic idle();
        bus.rd_sel_i = '0; bus.wr_en_i = '0; bus.wr_sel_i = '0; bus.wr_data_i = '0;
        bus.issue_en_i = 1'b0; bus.issue_sel_i = '0;
    endtask
    task automatic wr(input int p, input int sel, input logic [31:0] d);
        bus.wr_en_i[p] = 1'b1; bus.wr_sel_i[p*AW +: AW] = AW'(sel); bus.wr_data_i[p*DW +: DW] = d;
    endtask
    task automatic rd(input int p, input int sel);
        bus.rd_sel_i[p*AW +: AW] = AW'(sel);
    endtask
    task automatic iss(input int sel);
        bus.issue_en_i = 1'b1; bus.issue_sel_i = AW'(sel);
    endtask
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); wr(0, 1, 32'hAA); wr(1, 2, 32'hBB); iss(2);
        tick(); tick();
        rst_n = 1'b1; idle(); rd(0, 1); rd(1, 2);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL reset_rd0: got %h want %h", bus.rd_data_o[31:0], e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.rd_busy_o) !== e) begin n_bad++; $display("FAIL reset_busy: got %h want %h", bus.rd_busy_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL reset_cnt: got %0d want %0d", bus.busy_cnt_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.issue_stall_o) !== e) begin n_bad++; $display("FAIL reset_stall: got %0d want %0d", bus.issue_stall_o, e); end
        tick();
    endtask

    task automatic test_bypass();
        idle(); wr(0, 5, 32'h11); wr(1, 5, 32'h22); rd(0, 5);
        exp_q.push_back(32'h22);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL bypass_prio: got %h want %h", bus.rd_data_o[31:0], e); end
        tick();
        idle(); rd(0, 5); wr(0, 6, 32'h33); rd(1, 6);
        exp_q.push_back(32'h22); exp_q.push_back(32'h33);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL bypass_stored: got %h want %h", bus.rd_data_o[31:0], e); end
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[63:32] !== e) begin n_bad++; $display("FAIL bypass_rd1: got %h want %h", bus.rd_data_o[63:32], e); end
        tick();
        idle(); rd(1, 6);
        exp_q.push_back(32'h33);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[63:32] !== e) begin n_bad++; $display("FAIL bypass_rd1_stored: got %h want %h", bus.rd_data_o[63:32], e); end
        tick();
    endtask

    task automatic test_zero();
        idle(); wr(1, 0, 32'hDEAD); iss(0); rd(0, 0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL zero_bypass: got %h want %h", bus.rd_data_o[31:0], e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.issue_stall_o) !== e) begin n_bad++; $display("FAIL zero_stall: got %0d want %0d", bus.issue_stall_o, e); end
        tick();
        idle(); rd(0, 0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL zero_stored: got %h want %h", bus.rd_data_o[31:0], e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL zero_cnt: got %0d want %0d", bus.busy_cnt_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.rd_busy_o[0]) !== e) begin n_bad++; $display("FAIL zero_busy: got %0d want %0d", bus.rd_busy_o[0], e); end
        tick();
    endtask

    task automatic test_scoreboard();
        idle(); iss(3);
        exp_q.push_back(32'h0);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.issue_stall_o) !== e) begin n_bad++; $display("FAIL sb_first_stall: got %0d want %0d", bus.issue_stall_o, e); end
        tick();
        idle(); rd(0, 3); iss(3);
        exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.rd_busy_o[0]) !== e) begin n_bad++; $display("FAIL sb_busy: got %0d want %0d", bus.rd_busy_o[0], e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL sb_cnt: got %0d want %0d", bus.busy_cnt_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.issue_stall_o) !== e) begin n_bad++; $display("FAIL sb_waw_stall: got %0d want %0d", bus.issue_stall_o, e); end
        tick();
        idle(); rd(0, 3); wr(0, 3, 32'h7);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h7);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL sb_cnt_after_stall: got %0d want %0d", bus.busy_cnt_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.rd_busy_o[0]) !== e) begin n_bad++; $display("FAIL sb_retire_busy: got %0d want %0d", bus.rd_busy_o[0], e); end
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL sb_retire_data: got %h want %h", bus.rd_data_o[31:0], e); end
        tick();
        idle(); rd(0, 3);
        exp_q.push_back(32'h0); exp_q.push_back(32'h7);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL sb_cnt_freed: got %0d want %0d", bus.busy_cnt_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL sb_data_stored: got %h want %h", bus.rd_data_o[31:0], e); end
        tick();
    endtask

    task automatic test_issue_retire();
        idle(); iss(4);
        tick();
        idle(); rd(0, 4); iss(4); wr(0, 4, 32'h9);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h9);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.issue_stall_o) !== e) begin n_bad++; $display("FAIL ir_stall: got %0d want %0d", bus.issue_stall_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.rd_busy_o[0]) !== e) begin n_bad++; $display("FAIL ir_rd_busy: got %0d want %0d", bus.rd_busy_o[0], e); end
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL ir_data: got %h want %h", bus.rd_data_o[31:0], e); end
        tick();
        idle(); rd(0, 4);
        exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h9);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.rd_busy_o[0]) !== e) begin n_bad++; $display("FAIL ir_still_busy: got %0d want %0d", bus.rd_busy_o[0], e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL ir_cnt: got %0d want %0d", bus.busy_cnt_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL ir_stored: got %h want %h", bus.rd_data_o[31:0], e); end
        tick();
        idle(); wr(1, 4, 32'h10);
        tick();
        idle(); wr(0, 7, 32'h70);
        tick();
        idle(); rd(0, 7);
        exp_q.push_back(32'h0); exp_q.push_back(32'h70);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL ir_plain_write_cnt: got %0d want %0d", bus.busy_cnt_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL ir_plain_write: got %h want %h", bus.rd_data_o[31:0], e); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle(); wr(0, 13, 32'h77); iss(10);
        tick();
        idle(); iss(11);
        tick();
        idle(); iss(12);
        tick();
        idle();
        exp_q.push_back(32'd3);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL rm_cnt_before: got %0d want %0d", bus.busy_cnt_o, e); end
        rst_n = 1'b0; wr(0, 13, 32'hFF); iss(14);
        tick();
        rst_n = 1'b1; idle(); rd(0, 13); rd(1, 10);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL rm_data_cleared: got %h want %h", bus.rd_data_o[31:0], e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.rd_busy_o) !== e) begin n_bad++; $display("FAIL rm_busy_cleared: got %h want %h", bus.rd_busy_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL rm_cnt_cleared: got %0d want %0d", bus.busy_cnt_o, e); end
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[63:32] !== e) begin n_bad++; $display("FAIL rm_r10_cleared: got %h want %h", bus.rd_data_o[63:32], e); end
        tick();
        idle(); wr(0, 10, 32'hAB);
        tick();
        idle(); rd(0, 10);
        exp_q.push_back(32'hAB); exp_q.push_back(32'h0);
        #2;
        e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL rm_retire_after: got %h want %h", bus.rd_data_o[31:0], e); end
        e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL rm_cnt_after: got %0d want %0d", bus.busy_cnt_o, e); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] m_regs [NR];
        logic [NR-1:0] m_busy, ret;
        int m_cnt;
        int ws [NWR];
        logic [31:0] wd [NWR];
        logic we [NWR];
        int rsel [NRD];
        logic ie;
        int isel;
        logic stall;
        logic [31:0] v;
        rst_n = 1'b0; idle();
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        m_busy = '0; m_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            idle();
            for (int p = 0; p < NWR; p++) begin
                we[p] = ($urandom_range(2) == 0); ws[p] = $urandom_range(7); wd[p] = $urandom;
                if (we[p]) wr(p, ws[p], wd[p]);
            end
            for (int k = 0; k < NRD; k++) begin rsel[k] = $urandom_range(7); rd(k, rsel[k]); end
            ie = ($urandom_range(1) == 1); isel = $urandom_range(7);
            if (ie) iss(isel);
            ret = '0;
            for (int p = 0; p < NWR; p++) if (we[p] && ws[p] != 0) ret[ws[p]] = 1'b1;
            stall = ie && m_busy[isel] && !ret[isel];
            for (int k = 0; k < NRD; k++) begin
                v = m_regs[rsel[k]];
                for (int p = 0; p < NWR; p++) if (we[p] && ws[p] == rsel[k]) v = wd[p];
                exp_q.push_back(rsel[k] == 0 ? 32'h0 : v);
                exp_q.push_back(32'(m_busy[rsel[k]] && !ret[rsel[k]]));
            end
            exp_q.push_back(32'(stall));
            exp_q.push_back(32'(m_cnt));
            #2;
            e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[31:0] !== e) begin n_bad++; $display("FAIL b2b_rd0 c%0d: got %h want %h", c, bus.rd_data_o[31:0], e); end
            e = exp_q.pop_front(); n_cmp++; if (32'(bus.rd_busy_o[0]) !== e) begin n_bad++; $display("FAIL b2b_busy0 c%0d: got %0d want %0d", c, bus.rd_busy_o[0], e); end
            e = exp_q.pop_front(); n_cmp++; if (bus.rd_data_o[63:32] !== e) begin n_bad++; $display("FAIL b2b_rd1 c%0d: got %h want %h", c, bus.rd_data_o[63:32], e); end
            e = exp_q.pop_front(); n_cmp++; if (32'(bus.rd_busy_o[1]) !== e) begin n_bad++; $display("FAIL b2b_busy1 c%0d: got %0d want %0d", c, bus.rd_busy_o[1], e); end
            e = exp_q.pop_front(); n_cmp++; if (32'(bus.issue_stall_o) !== e) begin n_bad++; $display("FAIL b2b_stall c%0d: got %0d want %0d", c, bus.issue_stall_o, e); end
            e = exp_q.pop_front(); n_cmp++; if (32'(bus.busy_cnt_o) !== e) begin n_bad++; $display("FAIL b2b_cnt c%0d: got %0d want %0d", c, bus.busy_cnt_o, e); end
            for (int p = 0; p < NWR; p++) if (we[p] && ws[p] != 0) m_regs[ws[p]] = wd[p];
            m_busy = m_busy & ~ret;
            if (ie && isel != 0 && !stall) m_busy[isel] = 1'b1;
            m_cnt = $countones(m_busy);
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_issue_retire();
        test_reset_mid();
        test_back_to_back();
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
